// File: rtl/morph_input_capture.sv
// morph_input_capture: frame capture front-end for the morphology/histogram
// engine. Streams 256 pixel words into the image SRAM (one-cycle registered
// write), packs the 16 structuring-element bytes, latches and validates the
// op code, and tracks the frame minimum pixel.
// Optional macro SE_MIRROR_EN adds se_inv_out_o, the 180-degree rotated SE.
//
// state   | meaning
// IDLE    | waiting for the first beat of a frame
// CAPTURE | beats 1..255 of a frame being accepted
// DONE    | one-cycle frame-complete, results published
module morph_input_capture #(
  parameter int N_WORDS = 256,
  parameter int N_SE    = 16,
  parameter int ADDR_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid_i,
  input  logic              op_valid_i,
  input  logic [2:0]        op_i,
  input  logic [31:0]       pic_data_i,
  input  logic [7:0]        se_data_i,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  output logic [8*N_SE-1:0] se_out_o,
`ifdef SE_MIRROR_EN
  output logic [8*N_SE-1:0] se_inv_out_o,
`endif
  output logic [2:0]        op_out_o,
  output logic [7:0]        pix_min_o,
  output logic              busy_o,
  output logic              frame_done_o,
  output logic              op_err_o
);

  localparam int SE_W = $clog2(N_SE);
  localparam logic [ADDR_W-1:0] LAST_BEAT = ADDR_W'(N_WORDS - 1);
  localparam logic [ADDR_W-1:0] SE_LAST   = ADDR_W'(N_SE - 1);

  typedef enum logic [1:0] {IDLE, CAPTURE, DONE} state_t;

  state_t              state_q;
  logic [ADDR_W-1:0]   cnt_q;
  logic                op_seen_q;
  logic [7:0]          min_acc_q;
  logic                mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [31:0]         mem_wdata_q;
  logic [8*N_SE-1:0]   se_q;
  logic [2:0]          op_out_q;
  logic [7:0]          pix_min_q;
  logic                busy_q;
  logic                frame_done_q;
  logic                op_err_q;

  logic                start;
  logic [ADDR_W-1:0]   idx;
  logic [SE_W-1:0]     se_idx;
  logic [7:0]          min4;
  logic [7:0]          min_acc_d;
  logic                take_op;
  logic                op_seen_d;
  logic                op_err_d;
  logic [8*N_SE-1:0]   se_d;
`ifdef SE_MIRROR_EN
  logic [8*N_SE-1:0]   se_inv_q;
  logic [8*N_SE-1:0]   se_inv_d;
`endif

  function automatic logic [7:0] min2(input logic [7:0] a, input logic [7:0] b);
    return (a < b) ? a : b;
  endfunction

  // Per-beat next values; a beat seen outside CAPTURE opens a new frame.
  always_comb begin
    start     = in_valid_i && (state_q != CAPTURE);
    idx       = start ? '0 : cnt_q;
    se_idx    = idx[SE_W-1:0];
    min4      = min2(min2(pic_data_i[7:0], pic_data_i[15:8]),
                     min2(pic_data_i[23:16], pic_data_i[31:24]));
    min_acc_d = min2(start ? 8'hFF : min_acc_q, min4);
    take_op   = in_valid_i && op_valid_i && (start || !op_seen_q);
    op_seen_d = (start ? 1'b0 : op_seen_q) || take_op;
    op_err_d  = (start ? 1'b0 : op_err_q) ||
                (take_op && (op_i inside {3'd1, 3'd4, 3'd5}));
    se_d      = start ? '0 : se_q;
    if (idx <= SE_LAST) se_d[8*se_idx +: 8] = se_data_i;
`ifdef SE_MIRROR_EN
    se_inv_d  = start ? '0 : se_inv_q;
    if (idx <= SE_LAST) se_inv_d[8*(N_SE-1-32'(se_idx)) +: 8] = se_data_i;
`endif
  end

  // Capture FSM with all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      op_seen_q    <= 1'b0;
      min_acc_q    <= 8'hFF;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      se_q         <= '0;
      op_out_q     <= '0;
      pix_min_q    <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      op_err_q     <= 1'b0;
`ifdef SE_MIRROR_EN
      se_inv_q     <= '0;
`endif
    end else begin
      mem_we_q     <= in_valid_i;
      frame_done_q <= 1'b0;
      if (in_valid_i) begin
        mem_addr_q  <= idx;
        mem_wdata_q <= pic_data_i;
        min_acc_q   <= min_acc_d;
        op_seen_q   <= op_seen_d;
        op_err_q    <= op_err_d;
        se_q        <= se_d;
`ifdef SE_MIRROR_EN
        se_inv_q    <= se_inv_d;
`endif
        if (take_op) op_out_q <= op_i;
        busy_q      <= 1'b1;
        // Counter saturates on the last beat so it can never roll into a new frame.
        cnt_q       <= (idx == LAST_BEAT) ? idx : idx + ADDR_W'(1);
        if (idx == LAST_BEAT) begin
          state_q      <= DONE;
          frame_done_q <= 1'b1;
          pix_min_q    <= min_acc_d;
          if (!op_seen_d) begin
            op_err_q <= 1'b1;
            op_out_q <= '0;
          end
        end else begin
          state_q <= CAPTURE;
        end
      end else begin
        state_q <= IDLE;
        busy_q  <= 1'b0;
        // Beat missing mid-frame: truncated frame.
        if (state_q == CAPTURE) op_err_q <= 1'b1;
      end
    end
  end

  assign mem_we_o     = mem_we_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_wdata_o  = mem_wdata_q;
  assign se_out_o     = se_q;
  assign op_out_o     = op_out_q;
  assign pix_min_o    = pix_min_q;
  assign busy_o       = busy_q;
  assign frame_done_o = frame_done_q;
  assign op_err_o     = op_err_q;
`ifdef SE_MIRROR_EN
  assign se_inv_out_o = se_inv_q;
`endif

endmodule

// File: tb/tb_morph_input_capture.sv
// Directed testbench for morph_input_capture.
module tb_morph_input_capture;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid_i = 1'b0;
  logic         op_valid_i = 1'b0;
  logic [2:0]   op_i = '0;
  logic [31:0]  pic_data_i = '0;
  logic [7:0]   se_data_i = '0;
  logic         mem_we_o;
  logic [7:0]   mem_addr_o;
  logic [31:0]  mem_wdata_o;
  logic [127:0] se_out_o;
  logic [2:0]   op_out_o;
  logic [7:0]   pix_min_o;
  logic         busy_o;
  logic         frame_done_o;
  logic         op_err_o;
`ifdef SE_MIRROR_EN
  logic [127:0] se_inv_out_o;
`endif

  morph_input_capture dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid_i   (in_valid_i),
    .op_valid_i   (op_valid_i),
    .op_i         (op_i),
    .pic_data_i   (pic_data_i),
    .se_data_i    (se_data_i),
    .mem_we_o     (mem_we_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .se_out_o     (se_out_o),
`ifdef SE_MIRROR_EN
    .se_inv_out_o (se_inv_out_o),
`endif
    .op_out_o     (op_out_o),
    .pix_min_o    (pix_min_o),
    .busy_o       (busy_o),
    .frame_done_o (frame_done_o),
    .op_err_o     (op_err_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected SRAM write pipeline, built from what the bench drives.
  logic [7:0]  tb_beat = '0;
  logic        exp_we = 1'b0;
  logic [7:0]  exp_addr = '0;
  logic [31:0] exp_data = '0;
  bit          mon_en = 1'b0;
  int          cyc = 0;
  int          wr_cnt = 0;
  int          done_cnt = 0;
  int          done_cyc [8];
  logic [7:0]  done_min [8];
  logic        done_err [8];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst_n) exp_we <= 1'b0;
    else begin
      exp_we   <= in_valid_i;
      exp_addr <= tb_beat;
      exp_data <= pic_data_i;
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      chk("mem_we", 128'(mem_we_o), 128'(exp_we));
      if (exp_we) begin
        chk("mem_addr", 128'(mem_addr_o), 128'(exp_addr));
        chk("mem_wdata", 128'(mem_wdata_o), 128'(exp_data));
      end
    end
    if (mem_we_o === 1'b1) wr_cnt++;
    if (frame_done_o === 1'b1 && done_cnt < 8) begin
      done_cyc[done_cnt] = cyc;
      done_min[done_cnt] = pix_min_o;
      done_err[done_cnt] = op_err_o;
      done_cnt++;
    end
  end

  function automatic logic [31:0] pix_word(input int mode, input int b);
    logic [31:0] w;
    w = '0;
    for (int k = 0; k < 4; k++) begin
      case (mode)
        0:       w[8*k +: 8] = 8'((4*b + k) % 256);
        1:       w[8*k +: 8] = (b == 200 && k == 2) ? 8'h11 : 8'h80;
        default: w[8*k +: 8] = 8'hC0 - 8'((4*b + k) & 127);
      endcase
    end
    return w;
  endfunction

  function automatic logic [127:0] se_model(input logic [7:0] off);
    logic [127:0] s;
    for (int i = 0; i < 16; i++) s[8*i +: 8] = off + 8'(i);
    return s;
  endfunction

  task automatic drive_frame(input int n, input int mode, input int op_b, input logic [2:0] op_v,
                             input int op2_b, input logic [2:0] op2_v, input logic [7:0] se_off,
                             input bit keep);
    for (int b = 0; b < n; b++) begin
      @(posedge clk); #1;
      in_valid_i = 1'b1;
      tb_beat    = 8'(b);
      pic_data_i = pix_word(mode, b);
      se_data_i  = (b < 16) ? se_off + 8'(b) : 8'hAA;
      op_valid_i = (b == op_b) || (b == op2_b);
      op_i       = (b == op_b) ? op_v : ((b == op2_b) ? op2_v : 3'd3);
    end
    if (!keep) begin
      @(posedge clk); #1;
      in_valid_i = 1'b0;
      op_valid_i = 1'b0;
    end
  endtask

  // Called in the DONE cycle of a full frame.
  task automatic chk_done(input string t, input logic [2:0] op_e, input logic err_e,
                          input logic [7:0] min_e, input logic [7:0] se_off);
    chk({t, "_frame_done"}, 128'(frame_done_o), 128'd1);
    chk({t, "_busy_done"}, 128'(busy_o), 128'd1);
    chk({t, "_op_out"}, 128'(op_out_o), 128'(op_e));
    chk({t, "_op_err"}, 128'(op_err_o), 128'(err_e));
    chk({t, "_pix_min"}, 128'(pix_min_o), 128'(min_e));
    chk({t, "_se_out"}, se_out_o, se_model(se_off));
`ifdef SE_MIRROR_EN
    chk({t, "_se_inv_b0"}, 128'(se_inv_out_o[7:0]), 128'(se_model(se_off)[127:120]));
    for (int i = 0; i < 16; i++)
      chk({t, "_se_inv"}, 128'(se_inv_out_o[8*i +: 8]), 128'(se_off + 8'(15 - i)));
`endif
  endtask

  task automatic chk_idle_outputs(input string t);
    chk({t, "_mem_we"}, 128'(mem_we_o), 128'd0);
    chk({t, "_mem_addr"}, 128'(mem_addr_o), 128'd0);
    chk({t, "_mem_wdata"}, 128'(mem_wdata_o), 128'd0);
    chk({t, "_se_out"}, se_out_o, 128'd0);
    chk({t, "_op_out"}, 128'(op_out_o), 128'd0);
    chk({t, "_pix_min"}, 128'(pix_min_o), 128'd0);
    chk({t, "_busy"}, 128'(busy_o), 128'd0);
    chk({t, "_frame_done"}, 128'(frame_done_o), 128'd0);
    chk({t, "_op_err"}, 128'(op_err_o), 128'd0);
  endtask

  int d0, w0;

  initial begin
    // Power-on reset
    repeat (100) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    chk_idle_outputs("rst");
    mon_en = 1'b1;

    // Reset in the middle of a frame (op already latched)
    drive_frame(101, 0, 5, 3'd2, -1, 3'd0, 8'h00, 1'b1);
    @(posedge clk); #1;
    mon_en = 1'b0;
    rst_n = 1'b0; in_valid_i = 1'b0; op_valid_i = 1'b0;
    #1;
    chk_idle_outputs("midrst");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    mon_en = 1'b1;

    // Full ramp frame
    d0 = done_cnt; w0 = wr_cnt;
    drive_frame(256, 0, 5, 3'd2, -1, 3'd0, 8'h00, 1'b0);
    chk_done("ramp", 3'd2, 1'b0, 8'h00, 8'h00);
    repeat (3) @(posedge clk); #1;
    chk("ramp_busy_after", 128'(busy_o), 128'd0);
    chk("ramp_done_cnt", 128'(done_cnt - d0), 128'd1);
    chk("ramp_writes", 128'(wr_cnt - w0), 128'd256);
    chk("ramp_hold_op", 128'(op_out_o), 128'd2);

    // Flat frame with single minimum byte; second op pulse ignored
    drive_frame(256, 1, 15, 3'd0, 20, 3'd4, 8'h10, 1'b0);
    chk_done("flat", 3'd0, 1'b0, 8'h11, 8'h10);
    repeat (2) @(posedge clk);

    // Illegal op on beat 0
    drive_frame(256, 0, 0, 3'd5, -1, 3'd0, 8'h00, 1'b0);
    chk_done("illegal", 3'd5, 1'b1, 8'h00, 8'h00);
    repeat (2) @(posedge clk);

    // No op at all
    drive_frame(256, 2, -1, 3'd0, -1, 3'd0, 8'h30, 1'b0);
    chk_done("noop", 3'd0, 1'b1, 8'h41, 8'h30);
    repeat (2) @(posedge clk);

    // Truncated frame after beat 127
    d0 = done_cnt;
    drive_frame(128, 0, 3, 3'd2, -1, 3'd0, 8'h00, 1'b0);
    chk("trunc_busy_gap", 128'(busy_o), 128'd1);
    @(posedge clk); #1;
    chk("trunc_busy", 128'(busy_o), 128'd0);
    chk("trunc_op_err", 128'(op_err_o), 128'd1);
    repeat (3) @(posedge clk); #1;
    chk("trunc_no_done", 128'(done_cnt - d0), 128'd0);

    // Normal frame after truncation, op on the last beat
    drive_frame(256, 2, 255, 3'd7, -1, 3'd0, 8'h40, 1'b0);
    chk_done("post_trunc", 3'd7, 1'b0, 8'h41, 8'h40);
    repeat (2) @(posedge clk);

    // Two frames back-to-back, op of the second on its first beat (DONE cycle)
    d0 = done_cnt;
    drive_frame(256, 0, 5, 3'd2, -1, 3'd0, 8'h00, 1'b1);
    drive_frame(256, 2, 0, 3'd6, -1, 3'd0, 8'h20, 1'b0);
    chk_done("b2b", 3'd6, 1'b0, 8'h41, 8'h20);
    repeat (2) @(posedge clk); #1;
    chk("b2b_done_cnt", 128'(done_cnt - d0), 128'd2);
    if (done_cnt - d0 == 2) begin
      chk("b2b_gap", 128'(done_cyc[d0+1] - done_cyc[d0]), 128'd256);
      chk("b2b_min1", 128'(done_min[d0]), 128'h00);
      chk("b2b_err1", 128'(done_err[d0]), 128'd0);
      chk("b2b_min2", 128'(done_min[d0+1]), 128'h41);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/morph_input_capture.md
Name: morph_input_capture

Overview:
- Front-end capture stage sitting directly upstream of the morphology/histogram engine.
- Accepts the 256-beat frame stream: 4 pixels per 32-bit word, 32x32 8-bit image, row-major, with byte 0 as the leftmost pixel.
- Writes every word into the image SRAM, packs the 16 structuring-element (SE) bytes, latches and validates the op code, and tracks the frame minimum pixel for histogram equalisation.
- Pulses frame_done so the engine can start.

Parameters:
- N_WORDS, 256, pixel words per frame
- N_SE, 16, SE bytes per frame, taken on beats 0..N_SE-1
- ADDR_W, 8, SRAM word address width (clog2 N_WORDS)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  frame beat valid
- op_valid  in  1  op qualifier, single-beat pulse inside the frame
- op  in  3  operation code
- pic_data  in  32  four pixels, byte k = column 4*j+k
- se_data  in  8  SE byte, valid on beats 0..15 only
- mem_we  out  1  SRAM write strobe, active high
- mem_addr  out  ADDR_W  SRAM word address
- mem_wdata  out  32  SRAM write data
- se_out  out  128  packed SE, byte i = SE[i/4][i%4]
- op_out  out  3  latched op
- pix_min  out  8  minimum pixel of the frame
- busy  out  1  capture in progress
- frame_done  out  1  one-cycle pulse: frame complete and valid
- op_err  out  1  frame status: op missing or illegal (sticky until next frame)

Behaviour:
- Reset: all outputs 0 (pix_min resets to 0). Internal min accumulator resets to 8'hFF. State IDLE, beat counter 0.
- Reset asserted mid-frame: abort immediately, return all outputs to reset values. The next in_valid rising edge starts a fresh frame.
- FSM states: IDLE, CAPTURE, DONE.
- IDLE -> CAPTURE: on the first in_valid=1 cycle. That beat counts as beat 0.
  - On entry: clear op_err and the op-seen flag; set min accumulator to 8'hFF; clear se_out.
- CAPTURE:
  - Each in_valid=1 cycle is one beat; beat counter increments, 0..255.
  - Registered write, 1-cycle latency: cycle after beat b gives mem_we=1, mem_addr=b, mem_wdata=pic_data of beat b.
  - mem_we=0 whenever the previous cycle had no beat.
  - Beats 0..15: se_data of beat b goes to se_out byte b (se_out bits 8b+7:8b).
  - Beats >=16: se_data ignored (may be X).
  - op_valid=1 with in_valid=1 and op-seen clear: latch op into op_out and set op-seen.
    - If op is 3'd1, 3'd4 or 3'd5, set op_err.
    - Later op_valid pulses in the same frame are ignored.
  - Min accumulator = unsigned min of itself and all four bytes of every beat. A combinational 4-way min feeds the register.
  - in_valid=0 before beat 255: truncated frame.
    - Go to IDLE, no frame_done, op_err=1.
    - SRAM contents are undefined for the engine.
- Beat 255 -> DONE on the following cycle, in the same cycle as the final mem_we.
- DONE (exactly one cycle):
  - frame_done=1.
  - pix_min updated from the accumulator, including beat 255.
  - If op-seen is clear, op_err=1 and op_out=0.
  - Next state is IDLE.
- busy=1 from the first beat through the DONE cycle inclusive; 0 in IDLE.
- se_out, op_out, pix_min and op_err hold after DONE until the next frame start.
- in_valid=1 during DONE is the first beat of a new frame. Back-to-back frames are accepted with no gap, and the IDLE entry clears are applied in that cycle.
- Beat counter is ADDR_W bits. It must not wrap into a second frame: the counter saturates, and extra beats after 255 are treated as a new frame only after DONE.

Optional Feature:
- Macro: SE_MIRROR_EN.
- Defined: add output se_inv_out[127:0], registered alongside se_out.
  - se_inv_out byte i = se_out byte (15-i), i.e. SE_inv[k][kk] = SE[3-k][3-kk], so dilation needs no reorder.
  - Reset value 0; cleared at frame start.
- Not defined: port absent, no extra registers.

Test Plan:
- Reset: hold rst_n=0 for 100 cycles, then release -> all outputs 0, busy=0, mem_we=0. Reset mid-frame at beat 100 -> outputs 0, next frame captured correctly.
- Full frame, op=3'd2 on beat 5, se_data = b on beat b, pixel value = (4*beat+k)%256 -> 256 writes, addr 0..255 each one cycle after its beat. se_out=128'h0F0E..0100, op_out=2, op_err=0, pix_min=0, one frame_done pulse.
- Frame with all pixels 8'h80 except one byte 8'h11 on beat 200, op=3'd0 on beat 15 -> pix_min=8'h11. Second op_valid on beat 20 with op=3'd4 is ignored: op_out=0, op_err=0.
- Illegal op 3'd5 on beat 0 -> op_err=1 with frame_done=1. No op_valid at all -> op_err=1, op_out=0.
- in_valid drops after beat 127 -> no frame_done, op_err=1, busy returns to 0. A following full frame gives normal results.
- Two frames back-to-back with in_valid continuous for 512 cycles -> two frame_done pulses 256 cycles apart, second frame values independent of the first. With SE_MIRROR_EN defined, se_inv_out byte 0 equals se_out byte 15.
